mbox_wr_arb: RTL and testbench
==============================

// Module: mbox_wr_arb
// PURPOSE
// - Shares the single mailbox FIFO write controller between N_NUMB_CPU CPU ports.
// - Round-robin arbitration. Latches the winner's addr/data and drives one request downstream with its CPU index.
// - Tracks the per-CPU ack handshake from the controller and returns a one-cycle ack/err pulse to the winner.
// - Timeout guard: a wedged downstream cannot lock the bus.
// PARAMETERS
// - W_WIDTH_SYS  32   data word width
// - WIDTH_ADDR   32   mailbox address width
// - N_NUMB_CPU   4    number of CPU requesters (>=2)
// - TIMEOUT      64   max cycles to wait for downstream ack (>=8)
// PORTS
// - clk               in   1                    single clock, all logic on posedge
// - rst               in   1                    synchronous reset, active-high
// - cpu_req_i         in   N_NUMB_CPU           level request per CPU; held until its cpu_ack_o
// - cpu_wren_i        in   N_NUMB_CPU           1 = write request
// - cpu_addr_i        in   N_NUMB_CPU*WIDTH_ADDR   packed per-CPU address, CPU k at [k*WIDTH_ADDR +: WIDTH_ADDR]
// - cpu_data_i        in   N_NUMB_CPU*W_WIDTH_SYS  packed per-CPU write data
// - cpu_ack_o         out  N_NUMB_CPU           one-cycle completion pulse to the winner
// - cpu_err_o         out  N_NUMB_CPU           valid with cpu_ack_o: FIFO full, timeout or read rejected
// - m_req_o           out  1                    request to FIFO controller
// - m_wren_o          out  1                    always 1 while m_req_o
// - m_addr_o          out  WIDTH_ADDR           latched winner address
// - m_data_o          out  W_WIDTH_SYS          latched winner data
// - m_numb_cpu_o      out  32                   winner index, zero-extended
// - m_ack_i           in   N_NUMB_CPU           per-CPU ack from controller; stays high several cycles
// - m_err_i           in   1                    controller FIFO-full error flag
// - busy_o            out  1                    state != IDLE
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; rr_ptr=0; timeout counter 0. Reset mid-transaction aborts silently: no ack is issued.
// - States:
//   - IDLE: winner = first set cpu_req_i at or after rr_ptr (wrapping).
//     - Latch idx/addr/data.
//     - winner wren=1 -> REQ with m_req_o=1 next cycle.
//     - winner wren=0 -> REJ.
//     - No request -> stay in IDLE.
//   - REQ: m_req_o held high, m_* stable. Counter increments each cycle.
//     - m_ack_i[idx]=1 -> pulse cpu_ack_o[idx]; cpu_err_o[idx]=m_err_i sampled that cycle; m_req_o<=0; -> DRAIN.
//     - counter==TIMEOUT-1 with no ack -> pulse ack+err; m_req_o<=0; -> DRAIN.
//   - REJ: pulse cpu_ack_o[idx] and cpu_err_o[idx] for 1 cycle; -> IDLE. No downstream traffic.
//   - DRAIN: wait until m_ack_i == 0 (all bits); then -> IDLE. Re-arbitration happens only after this, so the controller is back in its idle state.
// - rr_ptr <= (idx+1) mod N_NUMB_CPU when leaving REQ or REJ. The wrap is an explicit compare, not a power-of-2 mask.
// - Latency:
//   - cpu_req_i sampled in IDLE at cycle 0 -> m_req_o high at cycle 1.
//   - cpu_ack_o occurs the cycle after m_ack_i[idx] rises.
//   - Minimum spacing between downstream requests: DRAIN + 1 IDLE cycle.
// - Acks on m_ack_i bits other than idx are ignored in REQ; DRAIN waits for them to clear.
// - cpu_req_i dropping mid-REQ does not cancel the transaction; the ack still pulses.
// - A requester that re-asserts immediately after its ack yields to all others pending.
// - Counter width $clog2(TIMEOUT)+1. Cleared on entry to REQ.
// STRUCTURE
// - mbox_pkg:
//   - typedef enum logic [1:0] {IDLE, REQ, REJ, DRAIN} arb_state_t
//   - localparam function for IDX_W = $clog2(N_NUMB_CPU)
// - Sub-module mbox_rr_pick: combinational.
//   - Inputs: req vector, rr_ptr. Outputs: valid, idx.
//   - Double-width masked priority encode.
// - Remaining logic: FSM, latches and counter in mbox_wr_arb.
// TESTING
// - Single CPU2 write, addr=0x10, data=0xCAFE.
//   - Expect m_req_o at cycle 1, m_addr_o=0x10, m_data_o=0xCAFE, m_numb_cpu_o=2.
//   - Expect one cpu_ack_o[2] pulse, err=0.
// - All 4 CPUs request simultaneously with rr_ptr=0 -> grant order 0,1,2,3.
//   - CPU0 re-requests at once -> served after CPU3.
// - Controller returns m_err_i=1 with ack for CPU1 -> cpu_ack_o[1]=cpu_err_o[1]=1 for exactly 1 cycle.
// - Downstream never acks, TIMEOUT=64.
//   - Expect ack+err at cycle 64 after m_req_o rise, m_req_o low.
//   - Next requester granted after m_ack_i==0.
// - CPU3 read request (wren=0) -> ack+err 2 cycles after request, m_req_o stays 0.
// - rst asserted in REQ -> next cycle all outputs 0, no cpu_ack_o; CPU re-request is served normally.

Source files
------------

// File: rtl/mbox_pkg.sv
// Shared types and sizing helpers for the mailbox write arbiter.
// The index-width helper is a function so each module can size ports from its own parameters.
package mbox_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        REJ   = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mbox_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
// The request vector is doubled so the wrap becomes a plain forward search.
module mbox_rr_pick
    import mbox_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [2*N-1:0] dbl;
    int             pick;
    logic           found;

    // NOTE: every variable gets a default before the search loop, so no path through this block can infer a latch.
    always_comb begin
        dbl   = {req_i, req_i};
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && (i >= int'(ptr_i)) && dbl[i]) begin
                found = 1'b1;
                pick  = i;
            end
        end
        if (pick >= N) begin
            pick = pick - N;
        end
        valid_o = |req_i;
        idx_o   = IDX_W'(pick);
    end

endmodule

// File: rtl/mbox_wr_arb.sv
// Round-robin arbiter sharing one mailbox FIFO write controller between CPU ports,
// with a per-transaction timeout so a wedged downstream cannot hold the bus.
module mbox_wr_arb
    import mbox_pkg::*;
#(
    parameter int W_WIDTH_SYS = 32,
    parameter int WIDTH_ADDR  = 32,
    parameter int N_NUMB_CPU  = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_NUMB_CPU-1:0]            cpu_req_i,
    input  logic [N_NUMB_CPU-1:0]            cpu_wren_i,
    input  logic [N_NUMB_CPU*WIDTH_ADDR-1:0] cpu_addr_i,
    input  logic [N_NUMB_CPU*W_WIDTH_SYS-1:0] cpu_data_i,
    output logic [N_NUMB_CPU-1:0]            cpu_ack_o,
    output logic [N_NUMB_CPU-1:0]            cpu_err_o,
    output logic                             m_req_o,
    output logic                             m_wren_o,
    output logic [WIDTH_ADDR-1:0]            m_addr_o,
    output logic [W_WIDTH_SYS-1:0]           m_data_o,
    output logic [31:0]                      m_numb_cpu_o,
    input  logic [N_NUMB_CPU-1:0]            m_ack_i,
    input  logic                             m_err_i,
    output logic                             busy_o
);

    localparam int IDX_W = idx_w(N_NUMB_CPU);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_NUMB_CPU - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    arb_state_t              state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        rr_ptr_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [N_NUMB_CPU-1:0]   cpu_ack_q;
    logic [N_NUMB_CPU-1:0]   cpu_err_q;
    logic                    m_req_q;
    logic [WIDTH_ADDR-1:0]   m_addr_q;
    logic [W_WIDTH_SYS-1:0]  m_data_q;
    logic [31:0]             m_numb_q;

    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;
    logic                    win_wren;
    logic [WIDTH_ADDR-1:0]   win_addr;
    logic [W_WIDTH_SYS-1:0]  win_data;

    mbox_rr_pick #(
        .N     (N_NUMB_CPU),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (cpu_req_i),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        win_wren = 1'b0;
        win_addr = '0;
        win_data = '0;
        for (int k = 0; k < N_NUMB_CPU; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                win_wren = cpu_wren_i[k];
                win_addr = cpu_addr_i[k*WIDTH_ADDR +: WIDTH_ADDR];
                win_data = cpu_data_i[k*W_WIDTH_SYS +: W_WIDTH_SYS];
            end
        end
    end

    // Explicit wrap so non-power-of-two CPU counts rotate correctly.
    assign rr_ptr_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

    // NOTE: state lives in always_ff with non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            cpu_ack_q <= '0;
            cpu_err_q <= '0;
            m_req_q   <= 1'b0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
            m_numb_q  <= '0;
        end else begin
            cpu_ack_q <= '0;
            cpu_err_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        idx_q    <= pick_idx;
                        m_addr_q <= win_addr;
                        m_data_q <= win_data;
                        m_numb_q <= 32'(pick_idx);
                        if (win_wren) begin
                            state_q <= REQ;
                            m_req_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= REJ;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (m_ack_i[idx_q]) begin
                        cpu_ack_q[idx_q] <= 1'b1;
                        cpu_err_q[idx_q] <= m_err_i;
                        m_req_q          <= 1'b0;
                        rr_ptr_q         <= rr_ptr_d;
                        state_q          <= DRAIN;
                    end else if (cnt_q == CNT_LIMIT) begin
                        cpu_ack_q[idx_q] <= 1'b1;
                        cpu_err_q[idx_q] <= 1'b1;
                        m_req_q          <= 1'b0;
                        rr_ptr_q         <= rr_ptr_d;
                        state_q          <= DRAIN;
                    end
                end
                REJ: begin
                    cpu_ack_q[idx_q] <= 1'b1;
                    cpu_err_q[idx_q] <= 1'b1;
                    rr_ptr_q         <= rr_ptr_d;
                    state_q          <= IDLE;
                end
                DRAIN: begin
                    if (m_ack_i == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ack_o    = cpu_ack_q;
    assign cpu_err_o    = cpu_err_q;
    assign m_req_o      = m_req_q;
    assign m_wren_o     = m_req_q;
    assign m_addr_o     = m_addr_q;
    assign m_data_o     = m_data_q;
    assign m_numb_cpu_o = m_numb_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_mbox_wr_arb.sv
// Directed bench for mbox_wr_arb: single write, round-robin order, error return,
// timeout, read rejection and reset mid-transaction.
module tb_mbox_wr_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      cpu_req_i;
    logic [N-1:0]      cpu_wren_i;
    logic [N*AW-1:0]   cpu_addr_i;
    logic [N*DW-1:0]   cpu_data_i;
    logic [N-1:0]      cpu_ack_o;
    logic [N-1:0]      cpu_err_o;
    logic              m_req_o;
    logic              m_wren_o;
    logic [AW-1:0]     m_addr_o;
    logic [DW-1:0]     m_data_o;
    logic [31:0]       m_numb_cpu_o;
    logic [N-1:0]      m_ack_i;
    logic              m_err_i;
    logic              busy_o;

    logic [AW-1:0] exp_addr [N];
    logic [DW-1:0] exp_data [N];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mbox_wr_arb #(
        .W_WIDTH_SYS (DW),
        .WIDTH_ADDR  (AW),
        .N_NUMB_CPU  (N),
        .TIMEOUT     (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req_i    (cpu_req_i),
        .cpu_wren_i   (cpu_wren_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_ack_o    (cpu_ack_o),
        .cpu_err_o    (cpu_err_o),
        .m_req_o      (m_req_o),
        .m_wren_o     (m_wren_o),
        .m_addr_o     (m_addr_o),
        .m_data_o     (m_data_o),
        .m_numb_cpu_o (m_numb_cpu_o),
        .m_ack_i      (m_ack_i),
        .m_err_i      (m_err_i),
        .busy_o       (busy_o)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One full write from grant to drain exit; starts with the arbiter in IDLE and the request pending.
    task automatic do_txn(input int k, input logic err, input logic keep);
        logic [N-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        step();
        chk("grant_req",  m_req_o, 1);
        chk("grant_wren", m_wren_o, 1);
        chk("grant_idx",  m_numb_cpu_o, k);
        chk("grant_addr", m_addr_o, exp_addr[k]);
        chk("grant_data", m_data_o, exp_data[k]);
        step();
        chk("req_hold", m_req_o, 1);
        chk("no_early_ack", cpu_ack_o, 0);
        m_ack_i = oh;
        m_err_i = err;
        step();
        chk("ack_pulse", cpu_ack_o, oh);
        chk("err_flag",  cpu_err_o, err ? oh : '0);
        chk("req_drop",  m_req_o, 0);
        m_err_i = 1'b0;
        if (!keep) cpu_req_i[k] = 1'b0;
        step();
        chk("ack_one_cycle", cpu_ack_o, 0);
        chk("drain_busy", busy_o, 1);
        m_ack_i = '0;
        step();
        chk("drain_exit", busy_o, 0);
    endtask

    initial begin
        exp_addr[0] = 32'h0000_0040; exp_data[0] = 32'h1111_0000;
        exp_addr[1] = 32'h0000_0100; exp_data[1] = 32'h2222_1111;
        exp_addr[2] = 32'h0000_0010; exp_data[2] = 32'h0000_CAFE;
        exp_addr[3] = 32'h0000_0300; exp_data[3] = 32'h4444_3333;
        for (int k = 0; k < N; k++) begin
            cpu_addr_i[k*AW +: AW] = exp_addr[k];
            cpu_data_i[k*DW +: DW] = exp_data[k];
        end
        rst        = 1'b1;
        cpu_req_i  = '0;
        cpu_wren_i = '0;
        m_ack_i    = '0;
        m_err_i    = 1'b0;
        step();
        step();
        chk("rst_req",  m_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ack",  cpu_ack_o, 0);
        chk("rst_numb", m_numb_cpu_o, 0);
        rst = 1'b0;

        // Single CPU2 write; rr_ptr moves to 3.
        cpu_req_i  = 4'b0100;
        cpu_wren_i = 4'b0100;
        do_txn(2, 1'b0, 1'b0);

        // CPU3 read: rejected two cycles after the request, no downstream traffic; rr_ptr wraps to 0.
        cpu_req_i  = 4'b1000;
        cpu_wren_i = 4'b0000;
        step();
        chk("rej_no_req", m_req_o, 0);
        chk("rej_no_ack_yet", cpu_ack_o, 0);
        step();
        chk("rej_ack", cpu_ack_o, 4'b1000);
        chk("rej_err", cpu_err_o, 4'b1000);
        chk("rej_no_req2", m_req_o, 0);
        cpu_req_i = '0;
        step();
        chk("rej_ack_clear", cpu_ack_o, 0);
        chk("rej_idle", busy_o, 0);

        // All four write at once; CPU0 keeps requesting and must wait behind 1,2,3. CPU1 gets FIFO-full.
        cpu_req_i  = 4'b1111;
        cpu_wren_i = 4'b1111;
        do_txn(0, 1'b0, 1'b1);
        do_txn(1, 1'b1, 1'b0);
        do_txn(2, 1'b0, 1'b0);
        do_txn(3, 1'b0, 1'b0);
        do_txn(0, 1'b0, 1'b0);

        // Timeout: CPU0 write never acked; a stray ack on bit 2 is ignored in REQ but holds DRAIN.
        cpu_req_i = 4'b0001;
        step();
        chk("to_req_rise", m_req_o, 1);
        m_ack_i = 4'b0100;
        for (int c = 0; c < TO - 1; c++) step();
        chk("to_no_ack_early", cpu_ack_o, 0);
        chk("to_req_still", m_req_o, 1);
        step();
        chk("to_ack", cpu_ack_o, 4'b0001);
        chk("to_err", cpu_err_o, 4'b0001);
        chk("to_req_low", m_req_o, 0);
        cpu_req_i = 4'b0010;
        step();
        step();
        chk("to_drain_hold", busy_o, 1);
        chk("to_drain_no_req", m_req_o, 0);
        m_ack_i = '0;
        step();
        chk("to_drain_exit", busy_o, 0);
        step();
        chk("to_next_req", m_req_o, 1);
        chk("to_next_idx", m_numb_cpu_o, 1);

        // Reset while CPU1 is in REQ: silent abort, then the held request is served normally.
        rst = 1'b1;
        step();
        chk("mid_rst_req",  m_req_o, 0);
        chk("mid_rst_wren", m_wren_o, 0);
        chk("mid_rst_addr", m_addr_o, 0);
        chk("mid_rst_data", m_data_o, 0);
        chk("mid_rst_numb", m_numb_cpu_o, 0);
        chk("mid_rst_ack",  cpu_ack_o, 0);
        chk("mid_rst_err",  cpu_err_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        rst = 1'b0;
        do_txn(1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
